// File: rtl/dsa_pixel_fetch_sequential.sv
// rtl/dsa_pixel_fetch_sequential.sv - bilinear neighbour fetch responder for the sequential datapath
module dsa_pixel_fetch_sequential #(
    parameter int IMG_WIDTH_MAX  = 512,
    parameter int IMG_HEIGHT_MAX = 512,
    parameter int ADDR_WIDTH     = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_req,
    input  logic [15:0]           current_x,
    input  logic [15:0]           current_y,
    input  logic [15:0]           img_width_in,
    input  logic [15:0]           img_height_in,
    input  logic [15:0]           scale_x,
    input  logic [15:0]           scale_y,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [7:0]            mem_rd_data,
    output logic [7:0]            p00,
    output logic [7:0]            p01,
    output logic [7:0]            p10,
    output logic [7:0]            p11,
    output logic [7:0]            frac_x,
    output logic [7:0]            frac_y,
    output logic                  fetch_done,
    output logic                  busy
);

    if ((64'd1 << ADDR_WIDTH) < 64'(IMG_WIDTH_MAX) * 64'(IMG_HEIGHT_MAX)) begin : g_addr_check
        $error("ADDR_WIDTH too small for IMG_WIDTH_MAX*IMG_HEIGHT_MAX");
    end

    typedef enum logic [2:0] {IDLE, CALC, ADDR, READ, DRAIN, DONE} state_t;

    state_t                state;
    logic [15:0]           cx, cy;
    logic [15:0]           x0, x1, y0, y1;
    logic [ADDR_WIDTH-1:0] addr_q [4];
    logic [1:0]            idx;

    // Returns {lo, hi, frac}; out-of-range positions clamp to the last pixel with zero weight.
    function automatic logic [39:0] map_axis(input logic [15:0] coord, input logic [15:0] scale,
                                             input logic [15:0] dim);
        logic [31:0] s;
        logic [15:0] d, lo, hi;
        logic [7:0]  f;
        s = {16'b0, coord} * {16'b0, scale};
        d = (dim == 16'd0) ? 16'd1 : dim;
        if (s[31:8] < {8'b0, d}) begin
            lo = s[23:8];
            f  = s[7:0];
        end else begin
            lo = d - 16'd1;
            f  = 8'd0;
        end
        hi = (({1'b0, lo} + 17'd1) < {1'b0, d}) ? lo + 16'd1 : lo;
        return {lo, hi, f};
    endfunction

    logic [39:0]           map_x, map_y;
    logic [15:0]           w_eff;
    logic [ADDR_WIDTH-1:0] row0, row1;

    always_comb begin
        map_x = map_axis(cx, scale_x, img_width_in);
        map_y = map_axis(cy, scale_y, img_height_in);
        w_eff = (img_width_in == 16'd0) ? 16'd1 : img_width_in;
        row0  = ADDR_WIDTH'(y0) * ADDR_WIDTH'(w_eff);
        row1  = ADDR_WIDTH'(y1) * ADDR_WIDTH'(w_eff);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cx         <= '0;
            cy         <= '0;
            x0         <= '0;
            x1         <= '0;
            y0         <= '0;
            y1         <= '0;
            idx        <= '0;
            for (int i = 0; i < 4; i++) addr_q[i] <= '0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            p00        <= '0;
            p01        <= '0;
            p10        <= '0;
            p11        <= '0;
            frac_x     <= '0;
            frac_y     <= '0;
            fetch_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_req) begin
                        cx    <= current_x;
                        cy    <= current_y;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    {x0, x1, frac_x} <= map_x;
                    {y0, y1, frac_y} <= map_y;
                    state            <= ADDR;
                end
                ADDR: begin
                    addr_q[0] <= row0 + ADDR_WIDTH'(x0);
                    addr_q[1] <= row0 + ADDR_WIDTH'(x1);
                    addr_q[2] <= row1 + ADDR_WIDTH'(x0);
                    addr_q[3] <= row1 + ADDR_WIDTH'(x1);
                    idx       <= 2'd0;
                    // First issue goes out straight from the sum so READ starts next cycle.
                    mem_rd_en <= 1'b1;
                    mem_addr  <= row0 + ADDR_WIDTH'(x0);
                    state     <= READ;
                end
                READ: begin
                    case (idx)
                        2'd1:    p00 <= mem_rd_data;
                        2'd2:    p01 <= mem_rd_data;
                        2'd3:    p10 <= mem_rd_data;
                        default: ;
                    endcase
                    if (idx == 2'd3) begin
                        mem_rd_en <= 1'b0;
                        state     <= DRAIN;
                    end else begin
                        mem_addr <= addr_q[idx + 2'd1];
                        idx      <= idx + 2'd1;
                    end
                end
                DRAIN: begin
                    p11        <= mem_rd_data;
                    fetch_done <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    fetch_done <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dsa_pixel_fetch_sequential.sv
// tb/tb_dsa_pixel_fetch_sequential.sv - scoreboard bench for dsa_pixel_fetch_sequential
module tb_dsa_pixel_fetch_sequential;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic [15:0] current_x = '0, current_y = '0;
    logic [15:0] img_width_in = 16'd4, img_height_in = 16'd4;
    logic [15:0] scale_x = 16'h0100, scale_y = 16'h0100;
    logic        mem_rd_en;
    logic [17:0] mem_addr;
    logic [7:0]  mem_rd_data = '0;
    logic [7:0]  p00, p01, p10, p11, frac_x, frac_y;
    logic        fetch_done, busy;

    dsa_pixel_fetch_sequential #(.IMG_WIDTH_MAX(512), .IMG_HEIGHT_MAX(512), .ADDR_WIDTH(18)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req),
        .current_x(current_x), .current_y(current_y),
        .img_width_in(img_width_in), .img_height_in(img_height_in),
        .scale_x(scale_x), .scale_y(scale_y),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .p00(p00), .p01(p01), .p10(p10), .p11(p11),
        .frac_x(frac_x), .frac_y(frac_y),
        .fetch_done(fetch_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Source memory: mem[a] = 3a, one-cycle read latency.
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= 8'(mem_addr * 3);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int c; int addr; } rd_exp_t;
    typedef struct { int c; logic [7:0] p [4]; logic [7:0] fx, fy; } done_exp_t;

    rd_exp_t   rd_q [$];
    done_exp_t done_q [$];
    int        n_cmp = 0, n_bad = 0;
    int        busy_lo = 1, busy_hi = 0;
    bit        mon_on = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT issues a read or signals completion.
    always @(negedge clk) begin
        if (mon_on) begin
            check("busy", busy, (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
            if (mem_rd_en) begin
                if (rd_q.size() == 0) begin
                    check("unexpected_read", 1, 0);
                end else begin
                    rd_exp_t e;
                    e = rd_q.pop_front();
                    check("read_cycle", cyc, e.c);
                    check("read_addr", mem_addr, e.addr);
                end
            end
            if (fetch_done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    done_exp_t d;
                    d = done_q.pop_front();
                    check("done_cycle", cyc, d.c);
                    check("p00", p00, d.p[0]);
                    check("p01", p01, d.p[1]);
                    check("p10", p10, d.p[2]);
                    check("p11", p11, d.p[3]);
                    check("frac_x", frac_x, d.fx);
                    check("frac_y", frac_y, d.fy);
                end
            end
        end
    end

    // One fetch; pulse_at re-pulses fetch_req in that cycle, rst_at drops rst_n in that cycle.
    task automatic do_fetch(input int x, input int y, input logic [15:0] scale,
                            input int a0, input int a1, input int a2, input int a3,
                            input logic [7:0] fx, input logic [7:0] fy,
                            input int pulse_at, input int rst_at);
        int c;
        int a [4];
        done_exp_t d;
        a = '{a0, a1, a2, a3};
        @(posedge clk); #1;
        c = cyc;
        scale_x = scale; scale_y = scale;
        current_x = 16'(x); current_y = 16'(y);
        fetch_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_exp_t e;
            e.c = c + 3 + i;
            e.addr = a[i];
            if (rst_at == 0 || e.c <= c + rst_at) rd_q.push_back(e);
        end
        if (rst_at == 0) begin
            d.c = c + 8;
            for (int i = 0; i < 4; i++) d.p[i] = 8'(a[i] * 3);
            d.fx = fx; d.fy = fy;
            done_q.push_back(d);
        end
        busy_lo = c + 1;
        busy_hi = (rst_at == 0) ? c + 8 : c + rst_at;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            fetch_req = (k == pulse_at);
            if (k == pulse_at) begin
                current_x = 16'd0; current_y = 16'd0;
            end
            rst_n = !(k == rst_at);
        end
        rst_n = 1'b1;
        fetch_req = 1'b0;
    endtask

    initial begin
        int timeout;
        fetch_req = 1'b1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        mon_on = 1'b1;
        @(posedge clk); #1;
        check("rst_mem_rd_en", mem_rd_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_pix", {p00, p01, p10, p11}, 0);
        check("rst_frac", {frac_x, frac_y}, 0);
        check("rst_done", fetch_done, 0);
        check("rst_busy", busy, 0);
        fetch_req = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_fetch(1, 2, 16'h0100, 9, 10, 13, 14, 8'h00, 8'h00, 0, 0);
        do_fetch(3, 1, 16'h0080, 1, 2, 5, 6, 8'h80, 8'h80, 0, 0);
        do_fetch(3, 3, 16'h0100, 15, 15, 15, 15, 8'h00, 8'h00, 0, 0);
        do_fetch(3, 0, 16'h0200, 3, 3, 7, 7, 8'h00, 8'h00, 0, 0);
        do_fetch(1, 2, 16'h0100, 9, 10, 13, 14, 8'h00, 8'h00, 4, 0);
        do_fetch(3, 1, 16'h0080, 1, 2, 5, 6, 8'h80, 8'h80, 0, 5);
        check("post_rst_pix", {p00, p01, p10, p11}, 0);
        check("post_rst_frac", {frac_x, frac_y}, 0);
        check("post_rst_done", fetch_done, 0);
        do_fetch(2, 1, 16'h0100, 6, 7, 10, 11, 8'h00, 8'h00, 0, 0);

        timeout = 0;
        while ((rd_q.size() != 0 || done_q.size() != 0) && timeout < 50) begin
            @(posedge clk); timeout++;
        end
        check("pending_reads", rd_q.size(), 0);
        check("pending_dones", done_q.size(), 0);
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
